// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: resolves EX-stage control flow, issues a fetch
// redirect with pipeline flushes, and maintains a 2-bit bimodal predictor.
module branch_redirect_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ex_valid,
  input  logic [6:0]  i_ex_opcode,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_ready,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic [15:0] o_mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_drain_cnt;
  logic [31:0] r_redirect_pc;
  logic [15:0] r_mispredict_cnt;
  logic [1:0]  r_bht [BHT_ENTRIES];

  logic             w_is_branch;
  logic             w_is_jal;
  logic             w_is_jalr;
  logic             w_idle;
  logic             w_mispredict;
  logic             w_bht_update;
  logic [31:0]      w_target;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [1:0]       w_ex_ctr;
  logic             w_unused;

  assign w_is_branch = (i_ex_opcode == OP_BRANCH);
  assign w_is_jal    = (i_ex_opcode == OP_JAL);
  assign w_is_jalr   = (i_ex_opcode == OP_JALR);
  assign w_idle      = (r_state == IDLE);

  assign w_mispredict = i_ex_valid & w_idle &
                        (w_is_jal | w_is_jalr | (w_is_branch & (i_ex_taken != i_ex_pred_taken)));

  assign w_target = (w_is_jal | w_is_jalr | (w_is_branch & i_ex_taken)) ? i_ex_target
                                                                       : i_ex_pc + 32'd4;

  assign w_if_idx     = i_if_pc[IDX_W+1:2];
  assign w_ex_idx     = i_ex_pc[IDX_W+1:2];
  assign w_ex_ctr     = r_bht[w_ex_idx];
  assign w_bht_update = i_ex_valid & w_idle & w_is_branch;

  // Lookup reads the registered array, so a same-cycle update is not visible yet
  assign o_pred_taken = r_bht[w_if_idx][1];

  assign w_unused = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_redirect_pc    <= '0;
      r_drain_cnt      <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_mispredict) begin
        r_redirect_pc <= w_target;
        if (r_mispredict_cnt != 16'hFFFF) begin
          r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
      end
      if ((r_state == REDIRECT) && i_redirect_ready) begin
        r_drain_cnt <= 3'(FLUSH_CYCLES);
      end else if ((r_state == DRAIN) && (r_drain_cnt != 3'd0)) begin
        r_drain_cnt <= r_drain_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_update) begin
      if (i_ex_taken) begin
        r_bht[w_ex_idx] <= (w_ex_ctr == 2'b11) ? 2'b11 : w_ex_ctr + 2'b01;
      end else begin
        r_bht[w_ex_idx] <= (w_ex_ctr == 2'b00) ? 2'b00 : w_ex_ctr - 2'b01;
      end
    end
  end

  always_comb begin
    w_next_state     = r_state;
    o_redirect_valid = 1'b0;
    o_flush_if_id    = 1'b0;
    o_flush_id_ex    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mispredict) begin
          w_next_state = REDIRECT;
        end
      end
      REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_flush_if_id    = 1'b1;
        o_flush_id_ex    = 1'b1;
        if (i_redirect_ready) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        // A zero count can only come from a corrupted state; fall back to IDLE
        if (r_drain_cnt <= 3'd1) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign o_redirect_pc    = r_redirect_pc;
  assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit predictor entries, power of two, 4..64.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, drain cycles after a redirect handshake, range 1..7.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-006 SHALL have port ex_opcode  input  7  EX opcode: 1100011 branch, 1101111 jal, 1100111 jalr.
REQ-007 SHALL have port ex_taken  input  1  resolved branch condition from the branch unit.
REQ-008 SHALL have port ex_pc  input  32  PC of the EX instruction.
REQ-009 SHALL have port ex_target  input  32  resolved target PC from the branch unit.
REQ-010 SHALL have port ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
REQ-011 SHALL have port if_pc  input  32  fetch PC for predictor lookup.
REQ-012 SHALL have port pred_taken  output  1  combinational prediction for if_pc.
REQ-013 SHALL have port redirect_valid  output  1  redirect request to fetch.
REQ-014 SHALL have port redirect_pc  output  32  new fetch PC, stable while redirect_valid=1.
REQ-015 SHALL have port redirect_ready  input  1  fetch accepts redirect.
REQ-016 SHALL have port flush_if_id  output  1  kill IF/ID register contents.
REQ-017 SHALL have port flush_id_ex  output  1  kill ID/EX register contents.
REQ-018 SHALL have port mispredict_cnt  output  16  saturating count of redirects issued.

Function
REQ-019 SHALL compute mispredict = ex_valid & state==IDLE & (jal | jalr | (branch & ex_taken != ex_pred_taken)).
REQ-020 SHALL select redirect target = ex_target when jal, jalr, or branch taken; else ex_pc+4, modulo 2^32.
REQ-021 SHALL implement states IDLE, REDIRECT, DRAIN; encoding is free.
REQ-022 IDLE: on mispredict, register target into redirect_pc and enter REDIRECT next cycle; otherwise stay in IDLE.
REQ-023 REDIRECT: drive redirect_valid=1, flush_if_id=1, flush_id_ex=1; on redirect_valid&redirect_ready, load drain counter with FLUSH_CYCLES and enter DRAIN.
REQ-024 REDIRECT SHALL hold indefinitely while redirect_ready=0, with redirect_pc unchanged.
REQ-025 DRAIN: drive flush_if_id=1, flush_id_ex=1, redirect_valid=0; decrement counter each cycle; return to IDLE in the cycle after the counter reaches 1.
REQ-026 Outside REDIRECT and DRAIN, flush_if_id, flush_id_ex and redirect_valid SHALL be 0.
REQ-027 All EX inputs SHALL be ignored in REDIRECT and DRAIN; no predictor update, no count.
REQ-028 Latency SHALL be exactly one cycle from mispredict to redirect_valid=1.
REQ-029 Predictor index SHALL be pc[log2(BHT_ENTRIES)+1:2]; pred_taken SHALL be the MSB of the indexed counter.
REQ-030 In IDLE, on ex_valid & branch, the indexed counter SHALL increment if ex_taken else decrement, saturating at 0 and 3; jal/jalr SHALL NOT update.
REQ-031 Same-cycle lookup and update of one entry SHALL return the pre-update value.
REQ-032 mispredict_cnt SHALL increment on each IDLE->REDIRECT transition and saturate at 0xFFFF.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, redirect_valid=0, flush_if_id=0, flush_id_ex=0, redirect_pc=0, drain counter=0, mispredict_cnt=0, all predictor counters=01.
REQ-034 rst asserted in REDIRECT or DRAIN SHALL abort the sequence immediately; no redirect SHALL be issued after release.

Verification
REQ-035 Reset, if_pc=0x100 -> pred_taken=0; beq taken at ex_pc=0x100, pred 0 -> next cycle redirect_valid=1, redirect_pc=ex_target, mispredict_cnt=1, counter[0x100]=10.
REQ-036 Branch not taken, pred 1, ex_pc=0x200 -> redirect_pc=0x204; redirect_ready held 0 for 3 cycles -> redirect_valid and redirect_pc stable for 4 cycles.
REQ-037 Handshake with FLUSH_CYCLES=2 -> flushes high for exactly 2 DRAIN cycles after handshake, then IDLE; EX mispredict injected during DRAIN -> ignored.
REQ-038 Four taken branches at one PC -> counter saturates at 11; four not-taken -> 00; correctly predicted branches -> no redirect, no count.
REQ-039 jalr at ex_pc=0xFFFFFFFC, ex_target=0x0 -> redirect_pc=0x0; not-taken at ex_pc=0xFFFFFFFC -> redirect_pc=0x0 (wrap).
REQ-040 rst pulsed mid-REDIRECT -> outputs 0 immediately, no redirect after release; 65536+ mispredicts -> mispredict_cnt holds 0xFFFF.
